// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the reloadable down-timer:
//   state_t     - timer control states (IDLE, RUN, HOLD, DONE)
//   CNT_WIDTH   - default counter / reload data width
//   accepts_load- true for every state in which a new reload value may be taken
// -----------------------------------------------------------------------------
package counter_pkg;

   localparam int CNT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Loads are refused only while counting down.
   function automatic logic accepts_load(input state_t s);
      return (s != ST_RUN);
   endfunction

endpackage

// File: rtl/down_timer_reload_if.sv
// -----------------------------------------------------------------------------
// down_timer_reload_if
// Reload-value handshake between a host (master) and the timer (slave).
//   load_valid - host requests a load of data
//   load_ready - timer accepts the load this cycle
//   data       - reload value
// -----------------------------------------------------------------------------
interface down_timer_reload_if
   import counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
) ();

   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] data;

   modport master (
      output load_valid,
      output data,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  data,
      output load_ready
   );

endinterface

// File: rtl/down_counter_core.sv
// -----------------------------------------------------------------------------
// down_counter_core
// Count register with load and saturating decrement.
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset, clears count
//   ld     - load ld_val (wins over dec)
//   ld_val - value to load
//   dec    - decrement by one; ignored when count is already zero
//   count  - registered count
// -----------------------------------------------------------------------------
module down_counter_core
   import counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             dec,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;

   // Count register: load has priority, decrement never wraps below zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= {WIDTH{1'b0}};
      end else if (ld) begin
         count_q <= ld_val;
      end else if (dec && (count_q != {WIDTH{1'b0}})) begin
         count_q <= count_q - WIDTH'(1);
      end else begin
         count_q <= count_q;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/down_timer_reload.sv
// -----------------------------------------------------------------------------
// down_timer_reload
// Down-counting timer with one-shot / auto-reload modes and pause/resume.
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset
//   ld_bus - reload handshake (load_valid, load_ready, data)
//   mode   - 0 one-shot, 1 auto-reload (sampled each cycle)
//   start  - start / resume countdown (ignored when count is zero)
//   stop   - pause countdown (only acts in RUN, overrides tick)
//   tick   - decrement strobe
//   count  - current count (registered)
//   tc     - one-cycle terminal-count pulse (registered)
//   busy   - high in RUN (registered)
//   done   - high in DONE (registered)
// -----------------------------------------------------------------------------
module down_timer_reload
   import counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   down_timer_reload_if.slave ld_bus,
   input  logic              mode,
   input  logic              start,
   input  logic              stop,
   input  logic              tick,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              busy,
   output logic              done
);

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] reload_q;
   logic             tc_q;
   logic             tc_d;
   logic             busy_q;
   logic             done_q;
   logic             ready_q;

   logic             load_fire;
   logic             cnt_ld;
   logic [WIDTH-1:0] cnt_ld_val;
   logic             cnt_dec;
   logic [WIDTH-1:0] count_s;

   down_counter_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst    (rst),
      .ld     (cnt_ld),
      .ld_val (cnt_ld_val),
      .dec    (cnt_dec),
      .count  (count_s)
   );

   // Datapath control: load request, terminal-count reload/clear, or plain decrement.
   always_comb begin
      load_fire  = 1'b0;
      cnt_ld     = 1'b0;
      cnt_ld_val = ld_bus.data;
      cnt_dec    = 1'b0;
      if (accepts_load(state_q)) begin
         load_fire = ld_bus.load_valid;
         cnt_ld    = ld_bus.load_valid;
      end else if (!stop && tick) begin
         if (count_s == CNT_ONE) begin
            // Terminal count: reload in auto mode, park at zero in one-shot.
            cnt_ld     = 1'b1;
            cnt_ld_val = mode ? reload_q : CNT_ZERO;
         end else begin
            cnt_dec = 1'b1;
         end
      end else begin
         cnt_dec = 1'b0;
      end
   end

   // Next-state and terminal-count decision.
   always_comb begin
      state_d = state_q;
      tc_d    = 1'b0;
      case (state_q)
         ST_IDLE, ST_HOLD, ST_DONE: begin
            if (load_fire) begin
               // A load keeps a paused timer paused; otherwise it lands in IDLE.
               state_d = (state_q == ST_HOLD) ? ST_HOLD : ST_IDLE;
            end else if (start && (count_s != CNT_ZERO)) begin
               state_d = ST_RUN;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_HOLD;
            end else if (tick && (count_s == CNT_ONE)) begin
               tc_d    = 1'b1;
               state_d = mode ? ST_RUN : ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller registers: state, reload value and all status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         reload_q <= CNT_ZERO;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         reload_q <= load_fire ? ld_bus.data : reload_q;
         tc_q     <= tc_d;
         busy_q   <= (state_d == ST_RUN);
         done_q   <= (state_d == ST_DONE);
         ready_q  <= accepts_load(state_d);
      end
   end

   assign count             = count_s;
   assign tc                = tc_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign ld_bus.load_ready = ready_q;

endmodule

// File: doc/down_timer_reload.md
DOWN_TIMER_RELOAD -- requirements
Module: down_timer_reload

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and data width in bits.
REQ-002 SHALL have port clk  input  1  clock, rising-edge active.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port load_valid  input  1  request to load data.
REQ-005 SHALL have port load_ready  output  1  load accepted this cycle if load_valid also high.
REQ-006 SHALL have port data  input  WIDTH  reload value.
REQ-007 SHALL have port mode  input  1  0 = one-shot, 1 = auto-reload; sampled every cycle.
REQ-008 SHALL have port start  input  1  start or resume countdown.
REQ-009 SHALL have port stop  input  1  pause countdown.
REQ-010 SHALL have port tick  input  1  decrement enable (prescaler strobe).
REQ-011 SHALL have port count  output  WIDTH  current count, registered.
REQ-012 SHALL have port tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-013 SHALL have port busy  output  1  high in RUN.
REQ-014 SHALL have port done  output  1  high in DONE.

Function
REQ-015 SHALL implement states IDLE, RUN, HOLD, DONE.
REQ-016 SHALL drive load_ready = 1 in IDLE, HOLD and DONE, and 0 in RUN.
REQ-017 SHALL, on load_valid && load_ready, set reload_q <= data and count <= data next cycle; the next state is IDLE from IDLE/DONE and HOLD from HOLD.
REQ-018 SHALL give load priority over start in the same cycle; start is then ignored.
REQ-019 SHALL, on start in IDLE/HOLD/DONE with count != 0 and no load, enter RUN next cycle.
REQ-020 SHALL ignore start when count == 0.
REQ-021 SHALL, in RUN with tick = 1 and count > 1, decrement count by 1 per tick; with tick = 0, count holds.
REQ-022 SHALL, in RUN with tick = 1 and count == 1, pulse tc for exactly the next cycle.
REQ-023 SHALL, in the REQ-022 case with mode = 1, set count <= reload_q and stay in RUN.
REQ-024 SHALL, in the REQ-022 case with mode = 0, set count <= 0 and enter DONE.
REQ-025 SHALL, on stop in RUN, enter HOLD with count frozen; stop overrides a same-cycle tick, with no decrement and no tc.
REQ-026 SHALL ignore stop outside RUN.
REQ-027 SHALL never wrap count below 0; count == 0 is never decremented.
REQ-028 SHALL hold tc = 0 in every cycle not described in REQ-022.
REQ-029 SHALL ignore start, stop and tick while count and state are in reset.

Reset
REQ-030 SHALL, while rst = 0, asynchronously force count = 0, reload_q = 0, tc = 0 and state = IDLE; busy = 0, done = 0 and load_ready = 1 follow from state = IDLE.
REQ-031 SHALL abort any countdown on reset mid-RUN, with no tc pulse generated.
REQ-032 SHALL resume normal operation on the first rising clk edge after rst returns to 1.

Structure
REQ-033 SHALL take the state enumeration and the WIDTH default from shared package counter_pkg.
REQ-034 SHALL place the count register with its load and decrement datapath in sub-module down_counter_core (inputs clk, rst, ld, ld_val, dec; output count); the FSM, reload_q and tc stay in the top level.

Verification
REQ-035 SHALL check that load 5, mode 0, start, tick always high gives count 5,4,3,2,1,0; tc is high in the single cycle count shows 0; then done = 1 and busy = 0.
REQ-036 SHALL check that load 3, mode 1, continuous tick gives count 3,2,1,3,2,1,3; tc pulses once per reload, with a period of 3 cycles.
REQ-037 SHALL check that load 10, start, 4 ticks, then stop with tick high gives HOLD at count 6 with no decrement; start then resumes from 6.
REQ-038 SHALL check that in IDLE, load_valid with data 7 and start in the same cycle gives count = 7, state IDLE and busy = 0; start alone then enters RUN.
REQ-039 SHALL check boundaries: start with count 0 is ignored; load_valid in RUN leaves load_ready = 0 and count unaffected.
REQ-040 SHALL check that rst driven low mid-RUN at count 4, asynchronously between clock edges, gives count 0, state IDLE and tc 0 immediately, with no tc pulse after release.
